// File: rtl/sccb_responder.sv
// SCCB target: oversampled sioc/siod, 3-phase write and 2-phase read decode, open-drain ack/data drive.
// Define SCCB_AUTOINC_EN for burst writes and sequential reads with sub-address auto-increment.
module sccb_responder #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       bus_error
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK, READ, READ_NA, RD_NEXT, IGNORE
  } state_t;

  state_t state, state_nx;

  // Synchronisers reset to the idle-bus level so reset release never looks like an edge.
  logic [SYNC_STAGES-1:0] sioc_sync, siod_sync;
  logic sioc_s, siod_s, sioc_q, siod_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sioc_sync <= '1;
      siod_sync <= '1;
      sioc_q    <= 1'b1;
      siod_q    <= 1'b1;
    end else begin
      sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
      siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod_in};
      sioc_q    <= sioc_s;
      siod_q    <= siod_s;
    end
  end

  assign sioc_s = sioc_sync[SYNC_STAGES-1];
  assign siod_s = siod_sync[SYNC_STAGES-1];

  logic sioc_rise, sioc_fall, start_ev, stop_ev;
  assign sioc_rise = sioc_s & ~sioc_q;
  assign sioc_fall = ~sioc_s & sioc_q;
  assign start_ev  = sioc_s & sioc_q & siod_q & ~siod_s;
  assign stop_ev   = sioc_s & sioc_q & ~siod_q & siod_s;

  logic [3:0] bit_cnt, bit_cnt_nx, bits_done;
  logic [7:0] shift, shift_nx, byte_in;
  logic       ack_on, ack_on_nx, rise_seen, rise_seen_nx;
  logic       oe_nx, wr_en_nx, busy_nx, err_nx, counting;
  logic [7:0] wr_addr_nx, wr_data_nx, rd_addr_nx;

  assign byte_in  = {shift[6:0], siod_s};
  // The rise that precedes STOP is the stop's own clock, not a data bit.
  assign bits_done = bit_cnt - {3'b000, rise_seen};
  assign counting  = (state == ID) || (state == SUB) || (state == DATA) || (state == READ);

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    shift_nx     = shift;
    ack_on_nx    = ack_on;
    rise_seen_nx = rise_seen;
    oe_nx        = siod_oe;
    wr_en_nx     = 1'b0;
    wr_addr_nx   = wr_addr;
    wr_data_nx   = wr_data;
    rd_addr_nx   = rd_addr;
    busy_nx      = busy;
    err_nx       = 1'b0;

    if (stop_ev) begin
      if (counting && bits_done != 4'd0) err_nx = 1'b1;
      state_nx     = IDLE;
      oe_nx        = 1'b0;
      busy_nx      = 1'b0;
      bit_cnt_nx   = '0;
      ack_on_nx    = 1'b0;
      rise_seen_nx = 1'b0;
    end else if (start_ev) begin
      state_nx     = ID;
      oe_nx        = 1'b0;
      bit_cnt_nx   = '0;
      ack_on_nx    = 1'b0;
      rise_seen_nx = 1'b0;
    end else begin
      if (sioc_fall) rise_seen_nx = 1'b0;
      unique case (state)
        IDLE: ;
        ID, SUB, DATA: if (sioc_rise) begin
          shift_nx = byte_in;
          if (bit_cnt == 4'd7) begin
            bit_cnt_nx = '0;
            if (state == ID) begin
              if (byte_in[7:1] == DEVICE_ID[7:1]) begin
                state_nx = ID_ACK;
                busy_nx  = 1'b1;
              end else begin
                state_nx = IGNORE;
              end
            end else if (state == SUB) begin
              rd_addr_nx = byte_in;
              state_nx   = SUB_ACK;
            end else begin
              wr_en_nx   = 1'b1;
              wr_addr_nx = rd_addr;
              wr_data_nx = byte_in;
`ifdef SCCB_AUTOINC_EN
              rd_addr_nx = rd_addr + 8'd1;
`endif
              state_nx   = DATA_ACK;
            end
          end else begin
            bit_cnt_nx   = bit_cnt + 4'd1;
            rise_seen_nx = 1'b1;
          end
        end
        ID_ACK, SUB_ACK, DATA_ACK: if (sioc_fall) begin
          // First fall pulls siod for the ninth clock, second fall ends it.
          if (!ack_on) begin
            ack_on_nx = 1'b1;
            oe_nx     = 1'b1;
          end else begin
            ack_on_nx  = 1'b0;
            oe_nx      = 1'b0;
            bit_cnt_nx = '0;
            if (state == ID_ACK) begin
              if (shift[0]) begin
                shift_nx = rd_data;
                oe_nx    = ~rd_data[7];
                state_nx = READ;
              end else begin
                state_nx = SUB;
              end
            end else if (state == SUB_ACK) begin
              state_nx = DATA;
            end else begin
`ifdef SCCB_AUTOINC_EN
              state_nx = DATA;
`else
              state_nx = IGNORE;
`endif
            end
          end
        end
        READ: begin
          if (sioc_rise) begin
            shift_nx = {shift[6:0], 1'b0};
            if (bit_cnt == 4'd7) begin
              bit_cnt_nx = '0;
              state_nx   = READ_NA;
            end else begin
              bit_cnt_nx   = bit_cnt + 4'd1;
              rise_seen_nx = 1'b1;
            end
          end else if (sioc_fall) begin
            oe_nx = ~shift[7];
          end
        end
        READ_NA: begin
          if (sioc_fall) begin
            oe_nx = 1'b0;
          end else if (sioc_rise) begin
`ifdef SCCB_AUTOINC_EN
            if (!siod_s) begin
              rd_addr_nx = rd_addr + 8'd1;
              state_nx   = RD_NEXT;
            end else begin
              state_nx = IGNORE;
            end
`else
            state_nx = IGNORE;
`endif
          end
        end
        RD_NEXT: if (sioc_fall) begin
          shift_nx   = rd_data;
          oe_nx      = ~rd_data[7];
          bit_cnt_nx = '0;
          state_nx   = READ;
        end
        IGNORE: if (sioc_fall) oe_nx = 1'b0;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ack_on    <= 1'b0;
      rise_seen <= 1'b0;
      siod_oe   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      ack_on    <= ack_on_nx;
      rise_seen <= rise_seen_nx;
      siod_oe   <= oe_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      rd_addr   <= rd_addr_nx;
      busy      <= busy_nx;
      bus_error <= err_nx;
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-banged SCCB master with open-drain pad model.
module tb_sccb_responder;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset, sioc, sda, siod_in, siod_oe;
  logic       wr_en, busy, bus_error;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h76;

  assign siod_in = sda & ~siod_oe;

  sccb_responder dut (
    .clk(clk), .reset(reset), .sioc(sioc), .siod_in(siod_in), .siod_oe(siod_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, rise_cyc = 0, wr_lat = 0, err_cnt = 0;
  logic busy_seen = 1'b0;
  logic [7:0] wq_addr[$], wq_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wr_lat = cyc - rise_cyc;
    end
    if (bus_error) err_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c;
    sda = 1'b1; wait_clk(Q);
    sioc = 1'b1; wait_clk(Q);
    sda = 1'b0; wait_clk(Q);
    sioc = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_c;
    sda = 1'b0; wait_clk(Q);
    sioc = 1'b1; wait_clk(Q);
    sda = 1'b1; wait_clk(2*Q);
  endtask

  task automatic clk_bit(input logic b, output logic pad);
    sda = b; wait_clk(Q);
    sioc = 1'b1; rise_cyc = cyc; wait_clk(Q);
    pad = siod_in; wait_clk(Q);
    sioc = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic p;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], p);
    clk_bit(1'b1, p);
    ack = ~p;
  endtask

  task automatic read_byte(input logic nine, output logic [7:0] d, output logic pad9);
    logic p;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, p);
      d[i] = p;
    end
    clk_bit(nine, pad9);
  endtask

  task automatic write_3(input logic [7:0] a, input logic [7:0] s, input logic [7:0] v,
                         output logic [2:0] acks);
    start_c;
    send_byte(a, acks[2]);
    send_byte(s, acks[1]);
    send_byte(v, acks[0]);
    stop_c;
  endtask

  task automatic test_write_basic(input string tag);
    logic [2:0] acks;
    int n0;
    n0 = wq_addr.size();
    busy_seen = 1'b0;
    write_3(8'h42, 8'h12, 8'h80, acks);
    check({tag, " acks"}, 32'(acks), 32'h7);
    check({tag, " wr count"}, 32'(wq_addr.size() - n0), 32'd1);
    if (wq_addr.size() > n0) begin
      check({tag, " wr_addr"}, 32'(wq_addr[n0]), 32'h12);
      check({tag, " wr_data"}, 32'(wq_data[n0]), 32'h80);
    end
    check({tag, " wr latency"}, 32'(wr_lat), 32'd3);
    check({tag, " busy seen"}, 32'(busy_seen), 32'd1);
    check({tag, " busy after stop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [2:0] acks;
    logic       ack, pad9;
    logic [7:0] d;
    int n0, e0;

    reset = 1'b1; sioc = 1'b1; sda = 1'b1;
    wait_clk(5);
    #1;
    check("reset outputs", 32'({siod_oe, wr_en, busy, bus_error}), 32'd0);
    check("reset regs", 32'({wr_addr, wr_data, rd_addr}), 32'd0);
    @(negedge clk); reset = 1'b0;
    wait_clk(5);

    // 1: single write
    e0 = err_cnt;
    test_write_basic("t1");
    check("t1 no error", 32'(err_cnt - e0), 32'd0);

    // 2: set sub-address, then read
    n0 = wq_addr.size();
    start_c;
    send_byte(8'h42, acks[1]);
    send_byte(8'h0A, acks[0]);
    stop_c;
    check("t2 write acks", 32'(acks[1:0]), 32'h3);
    check("t2 rd_addr", 32'(rd_addr), 32'h0A);
    start_c;
    send_byte(8'h43, ack);
    check("t2 read id ack", 32'(ack), 32'd1);
    read_byte(1'b1, d, pad9);
    stop_c;
    check("t2 read data", 32'(d), 32'h76);
    check("t2 NA released", 32'(pad9), 32'd1);
    check("t2 no write", 32'(wq_addr.size() - n0), 32'd0);
    check("t2 no error", 32'(err_cnt - e0), 32'd0);

    // 3: other device id
    n0 = wq_addr.size();
    busy_seen = 1'b0;
    write_3(8'h60, 8'h12, 8'h80, acks);
    check("t3 acks", 32'(acks), 32'd0);
    check("t3 busy", 32'(busy_seen), 32'd0);
    check("t3 no write", 32'(wq_addr.size() - n0), 32'd0);
    check("t3 no error", 32'(err_cnt - e0), 32'd0);

    // 4: STOP mid data byte
    n0 = wq_addr.size();
    start_c;
    send_byte(8'h42, acks[1]);
    send_byte(8'h33, acks[0]);
    clk_bit(1'b1, pad9); clk_bit(1'b0, pad9); clk_bit(1'b1, pad9); clk_bit(1'b0, pad9);
    stop_c;
    check("t4 error pulse", 32'(err_cnt - e0), 32'd1);
    check("t4 no write", 32'(wq_addr.size() - n0), 32'd0);
    check("t4 busy", 32'(busy), 32'd0);
    e0 = err_cnt;

    // 5: reset while acking the id
    start_c;
    for (int i = 7; i >= 0; i--) begin
      d = 8'h42;
      clk_bit(d[i], pad9);
    end
    sda = 1'b1;
    check("t5 acking", 32'(siod_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("t5 oe on reset", 32'(siod_oe), 32'd0);
    check("t5 busy on reset", 32'(busy), 32'd0);
    sioc = 1'b1; sda = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    test_write_basic("t5");
    e0 = err_cnt;

    // 6: burst write FF,11,22
    n0 = wq_addr.size();
    start_c;
    send_byte(8'h42, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    check("t6 third ack", 32'(ack), 32'd1);
    send_byte(8'h22, ack);
    stop_c;
`ifdef SCCB_AUTOINC_EN
    check("t6 fourth ack", 32'(ack), 32'd1);
    check("t6 wr count", 32'(wq_addr.size() - n0), 32'd2);
    if (wq_addr.size() >= n0 + 2) begin
      check("t6 w0", 32'({wq_addr[n0], wq_data[n0]}), 32'hFF11);
      check("t6 w1", 32'({wq_addr[n0+1], wq_data[n0+1]}), 32'h0022);
    end
`else
    check("t6 fourth ack", 32'(ack), 32'd0);
    check("t6 wr count", 32'(wq_addr.size() - n0), 32'd1);
    if (wq_addr.size() >= n0 + 1)
      check("t6 w0", 32'({wq_addr[n0], wq_data[n0]}), 32'hFF11);
`endif
    check("t6 no error", 32'(err_cnt - e0), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
